// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
//
// Central hazard and sequencing controller for the five-stage MIPS pipeline.
// Decides, every cycle, whether the pipeline freezes (data memory wait),
// inserts a bubble (load-use, branch operand or multiply/divide dependency),
// or flushes IF/ID (taken branch). It also tracks multiply/divide occupancy
// and counts the cycles in which the PC was held.
//
// Parameters
//   MULT_CYCLES    busy cycles for a multiply (>= 1)
//   DIV_CYCLES     busy cycles for a divide   (>= 1)
//
// Ports
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   id_rs/id_rt    source registers of the ID instruction
//   id_branch      ID instruction compares rs/rt in ID
//   id_uses_hilo   ID instruction reads/writes HI/LO
//   branch_taken   branch/jump in ID resolved taken
//   ex_mem_read    EX instruction is a load
//   ex_reg_write   EX instruction writes a register
//   ex_write_reg   EX destination register
//   mem_mem_read   MEM instruction is a load
//   mem_write_reg  MEM destination register
//   md_start       EX instruction is mult/div
//   md_is_div      qualifies md_start: 1 = divide
//   dmem_req       MEM-stage data access request
//   dmem_ready     MEM-stage data access completion
//   stall_*        hold PC / IF/ID / ID/EX / EX/MEM
//   clear_*        zero IF/ID / ID/EX / MEM/WB on the next edge
//   md_busy        multiply/divide unit occupied
//   stall_cycles   saturating count of cycles with stall_pc=1
// ---------------------------------------------------------------------------
module hazard_controller #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_branch,
  input  logic        id_uses_hilo,
  input  logic        branch_taken,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_write_reg,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_write_reg,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        stall_pc,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        clear_id,
  output logic        clear_ex,
  output logic        clear_wb,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  // Counter wide enough to hold the larger busy length minus one.
  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = ($clog2(MAXC) > 0) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_MD_BUSY = 1'b1;

  logic [0:0]    r_state;
  logic [CW-1:0] r_count;
  logic [31:0]   r_stall_cycles;

  logic w_ex_match;
  logic w_mem_match;
  logic w_freeze;
  logic w_load_use;
  logic w_branch_dep;
  logic w_md_dep;
  logic w_bubble;
  logic w_flush;
  logic w_md_busy;

  // ------------------------------------------------------------------------
  // Hazard detection. Register 0 is hard-wired zero, so it never creates a
  // dependency.
  // ------------------------------------------------------------------------
  assign w_ex_match  = (ex_write_reg != 5'd0) &&
                       ((ex_write_reg == id_rs) || (ex_write_reg == id_rt));
  assign w_mem_match = (mem_write_reg != 5'd0) &&
                       ((mem_write_reg == id_rs) || (mem_write_reg == id_rt));

  assign w_md_busy    = (r_state == S_MD_BUSY);
  assign w_freeze     = dmem_req & ~dmem_ready;
  assign w_load_use   = ex_mem_read & w_ex_match;
  // Branches compare in ID, so they need an EX result (any writer) or a
  // MEM-stage load result that is not yet forwardable.
  assign w_branch_dep = id_branch & ((ex_reg_write & w_ex_match) |
                                     (mem_mem_read & w_mem_match));
  assign w_md_dep     = w_md_busy & id_uses_hilo;

  // Freeze dominates: the whole pipe holds and hazards are re-evaluated once
  // memory answers. A bubble dominates a flush: the branch in ID is held and
  // its taken decision is re-evaluated next cycle.
  assign w_bubble = ~w_freeze & (w_load_use | w_branch_dep | w_md_dep);
  assign w_flush  = ~w_freeze & ~w_bubble & branch_taken;

  always_comb begin
    stall_pc  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    clear_id  = 1'b0;
    clear_ex  = 1'b0;
    clear_wb  = 1'b0;
    if (!reset_n) begin
      // Pipeline registers have no reset of their own; flush them instead.
      clear_id = 1'b1;
      clear_ex = 1'b1;
      clear_wb = 1'b1;
    end else if (w_freeze) begin
      stall_pc  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      // MEM/WB gets a bubble so WB does not retire the stalled access twice.
      clear_wb  = 1'b1;
    end else if (w_bubble) begin
      stall_pc = 1'b1;
      stall_id = 1'b1;
      clear_ex = 1'b1;
    end else if (w_flush) begin
      clear_id = 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // Multiply/divide occupancy. Loading N-1 and leaving on count==0 keeps
  // md_busy high for exactly N cycles after the start edge. The count runs
  // through freezes because the unit itself is not stalled.
  // ------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A start held during a freeze is not taken until the freeze ends.
          if (md_start && !w_freeze) begin
            r_state <= S_MD_BUSY;
            r_count <= md_is_div ? DIV_LOAD : MULT_LOAD;
          end
        end
        S_MD_BUSY: begin
          if (r_count == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  assign md_busy = w_md_busy;

  // ------------------------------------------------------------------------
  // Stall-cycle performance counter, saturating at all ones.
  // ------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles <= '0;
    end else if (stall_pc && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
//
// Directed-vector bench for hazard_controller. Inputs change on the falling
// edge; combinational outputs are sampled 1 ns later, and registered state is
// sampled after the following rising edge has passed.
// ---------------------------------------------------------------------------
module tb_hazard_controller;

  logic        clock;
  logic        reset_n;
  logic [4:0]  id_rs, id_rt;
  logic        id_branch, id_uses_hilo, branch_taken;
  logic        ex_mem_read, ex_reg_write;
  logic [4:0]  ex_write_reg;
  logic        mem_mem_read;
  logic [4:0]  mem_write_reg;
  logic        md_start, md_is_div;
  logic        dmem_req, dmem_ready;
  logic        stall_pc, stall_id, stall_ex, stall_mem;
  logic        clear_id, clear_ex, clear_wb;
  logic        md_busy;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt;

  hazard_controller #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_branch    (id_branch),
    .id_uses_hilo (id_uses_hilo),
    .branch_taken (branch_taken),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .ex_write_reg (ex_write_reg),
    .mem_mem_read (mem_mem_read),
    .mem_write_reg(mem_write_reg),
    .md_start     (md_start),
    .md_is_div    (md_is_div),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .stall_pc     (stall_pc),
    .stall_id     (stall_id),
    .stall_ex     (stall_ex),
    .stall_mem    (stall_mem),
    .clear_id     (clear_id),
    .clear_ex     (clear_ex),
    .clear_wb     (clear_wb),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Packs {stall_pc,stall_id,stall_ex,stall_mem,clear_id,clear_ex,clear_wb}.
  function automatic logic [31:0] ctl();
    return {25'd0, stall_pc, stall_id, stall_ex, stall_mem, clear_id, clear_ex, clear_wb};
  endfunction

  // Advance one full cycle: through the rising edge to the next falling edge.
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_branch = 1'b0; id_uses_hilo = 1'b0;
    branch_taken = 1'b0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    ex_write_reg = 5'd0; mem_mem_read = 1'b0; mem_write_reg = 5'd0;
    md_start = 1'b0; md_is_div = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    #1;
    // ---- reset state --------------------------------------------------
    chk("rst_ctl",    ctl(),        32'b0000_111);
    chk("rst_busy",   md_busy,      32'd0);
    chk("rst_cnt",    stall_cycles, 32'd0);

    reset_n = 1'b1;
    #1;
    chk("idle_ctl", ctl(), 32'b0000_000);
    cyc();

    // ---- load-use -----------------------------------------------------
    ex_mem_read = 1'b1; ex_write_reg = 5'd8; id_rs = 5'd8;
    #1;
    chk("lu_ctl", ctl(), 32'b1100_010);
    cyc();
    chk("lu_cnt", stall_cycles, 32'd1);
    ex_write_reg = 5'd0; id_rs = 5'd0;
    #1;
    chk("lu_r0_ctl", ctl(), 32'b0000_000);
    cyc();
    chk("lu_r0_cnt", stall_cycles, 32'd1);
    idle_inputs();

    // ---- branch flush and bubble priority -----------------------------
    branch_taken = 1'b1;
    #1;
    chk("flush_ctl", ctl(), 32'b0000_100);
    cyc();
    id_branch = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd5; id_rt = 5'd5;
    #1;
    chk("br_dep_ctl", ctl(), 32'b1100_010);
    cyc();
    chk("br_dep_cnt", stall_cycles, 32'd2);
    // MEM-stage load feeding a branch; non-load MEM writer is no hazard.
    idle_inputs();
    id_branch = 1'b1; mem_write_reg = 5'd9; id_rs = 5'd9;
    #1;
    chk("br_mem_nold", ctl(), 32'b0000_000);
    mem_mem_read = 1'b1;
    #1;
    chk("br_mem_ld", ctl(), 32'b1100_010);
    cyc();
    idle_inputs();
    // stall_cycles = 3

    // ---- multiply: 4 busy cycles with a HI/LO consumer in ID ----------
    md_start = 1'b1; md_is_div = 1'b0;
    #1;
    chk("mul_pre_busy", md_busy, 32'd0);
    cyc();
    md_start = 1'b0; id_uses_hilo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mul_busy%0d", i), {md_busy, stall_pc, clear_ex}, 32'b111);
      cyc();
    end
    #1;
    chk("mul_done", {md_busy, stall_pc, clear_ex}, 32'b000);
    chk("mul_cnt", stall_cycles, 32'd7);
    idle_inputs();
    cyc();

    // ---- divide: 32 busy cycles, start ignored while busy -------------
    md_start = 1'b1; md_is_div = 1'b1;
    cyc();
    md_start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (md_busy) busy_cnt++;
      if (i == 2) md_start = 1'b1;   // must not restart the count
      if (i == 3) md_start = 1'b0;
      cyc();
    end
    chk("div_len", busy_cnt, 32'd32);
    chk("div_cnt", stall_cycles, 32'd7);
    idle_inputs();

    // ---- memory wait with load-use and md_start pending ---------------
    dmem_req = 1'b1; dmem_ready = 1'b0;
    ex_mem_read = 1'b1; ex_write_reg = 5'd3; id_rt = 5'd3;
    md_start = 1'b1; md_is_div = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("frz_ctl%0d", i), ctl(), 32'b1111_001);
      cyc();
      chk($sformatf("frz_busy%0d", i), md_busy, 32'd0);
    end
    chk("frz_cnt", stall_cycles, 32'd10);
    dmem_ready = 1'b1;
    #1;
    chk("frz_rel_ctl", ctl(), 32'b1100_010);
    cyc();
    chk("frz_rel_busy", md_busy, 32'd1);
    chk("frz_rel_cnt", stall_cycles, 32'd11);
    idle_inputs();
    for (int i = 0; i < 4; i++) cyc();
    chk("frz_mul_end", md_busy, 32'd0);

    // ---- saturation ---------------------------------------------------
    force dut.r_stall_cycles = 32'hFFFF_FFFD;
    #1;
    release dut.r_stall_cycles;
    @(negedge clock);
    ex_mem_read = 1'b1; ex_write_reg = 5'd7; id_rs = 5'd7;
    cyc();
    chk("sat_m1", stall_cycles, 32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++) cyc();
    chk("sat_hold", stall_cycles, 32'hFFFF_FFFF);
    idle_inputs();

    // ---- reset in the middle of a divide ------------------------------
    md_start = 1'b1; md_is_div = 1'b1;
    cyc();
    md_start = 1'b0;
    ex_mem_read = 1'b1; ex_write_reg = 5'd4; id_rs = 5'd4;
    cyc();
    cyc();
    chk("mid_div_busy", md_busy, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", md_busy, 32'd0);
    chk("arst_cnt", stall_cycles, 32'd0);
    chk("arst_ctl", ctl(), 32'b0000_111);
    idle_inputs();
    @(negedge clock);
    reset_n = 1'b1;
    cyc();
    chk("post_rst_busy", md_busy, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Central hazard and sequencing controller for the five-stage pipelined MIPS core. Watches register-use and control information from the ID, EX and MEM stages and the data-memory handshake, and drives the `stall`/`clear` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. Tracks multi-cycle multiply/divide occupancy with an internal state machine and counter, and keeps a saturating stall-cycle performance counter.

## Interface
- MULT_CYCLES, 4, busy cycles for a multiply (≥1)
- DIV_CYCLES, 32, busy cycles for a divide (≥1)
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  5 each  source registers of instruction in ID
- id_branch  in  1  ID instruction is a branch comparing rs/rt in ID
- id_uses_hilo  in  1  ID instruction is mfhi/mflo/mult/div
- branch_taken  in  1  branch/jump in ID resolved taken
- ex_mem_read, ex_reg_write  in  1 each  EX instruction is a load / writes a register
- ex_write_reg  in  5  EX destination register
- mem_mem_read  in  1  MEM instruction is a load
- mem_write_reg  in  5  MEM destination register
- md_start  in  1  EX instruction is mult/div
- md_is_div  in  1  qualifies md_start: 1 = divide
- dmem_req, dmem_ready  in  1 each  MEM-stage access request / completion
- stall_pc, stall_id, stall_ex, stall_mem  out  1 each  hold PC / IF/ID / ID/EX / EX/MEM
- clear_id, clear_ex, clear_wb  out  1 each  zero IF/ID / ID/EX / MEM/WB on next edge
- md_busy  out  1  multiply/divide unit occupied
- stall_cycles  out  32  saturating count of cycles with stall_pc=1

## Operation
- Register matches ignore register 0.
- freeze = dmem_req & !dmem_ready. Highest priority: stall_pc=stall_id=stall_ex=stall_mem=1, clear_wb=1; all other clears 0.
- load_use = ex_mem_read & ex_write_reg ∈ {id_rs, id_rt}.
- branch_dep = id_branch & ((ex_reg_write & ex_write_reg match) | (mem_mem_read & mem_write_reg match)).
- md_dep = md_busy & id_uses_hilo.
- bubble = !freeze & (load_use | branch_dep | md_dep): stall_pc=stall_id=1, clear_ex=1.
- flush = !freeze & !bubble & branch_taken: clear_id=1.
- Otherwise all stall/clear outputs 0.
- FSM states IDLE, MD_BUSY. IDLE: if md_start & !freeze → MD_BUSY, count ← (md_is_div ? DIV_CYCLES : MULT_CYCLES) − 1. MD_BUSY: count decrements every cycle (including during freeze); at count==0 → IDLE. md_start in MD_BUSY ignored.
- md_busy = (state==MD_BUSY).
- stall_cycles increments by 1 each edge where stall_pc=1; saturates at 0xFFFF_FFFF.
- While reset_n=0: clear_id=clear_ex=clear_wb=1, all stalls 0, md_busy 0 (pipeline registers have no reset; flush them via clears).

## Timing
- All stall/clear outputs combinational from inputs and state; take effect at the next rising edge of clock.
- Reset (async, immediate): state IDLE, count 0, stall_cycles 0; outputs as above. Deassertion synchronous to next edge behaviour.
- md_start sampled at edge T → md_busy=1 from T through T+N−1 edges (N cycles high), 0 after.
- MULT_CYCLES=1: md_busy high exactly one cycle.
- Simultaneous load_use and branch_taken: bubble wins, no clear_id; branch re-evaluated next cycle.
- Simultaneous freeze and any hazard: freeze only; hazard re-evaluated after dmem_ready.
- md_start held during freeze: not sampled until freeze clears.
- Reset mid-MD_BUSY: returns to IDLE immediately, md_busy=0.

## Test plan
- Load-use: ex_mem_read=1, ex_write_reg=8, id_rs=8 for one cycle → stall_pc=stall_id=clear_ex=1 that cycle, stall_cycles 0→1; with ex_write_reg=0 → no stall.
- Branch flush: branch_taken=1, no hazards → clear_id=1 only; with id_branch, ex_reg_write=1, ex_write_reg=id_rt=5 simultaneously → bubble, clear_id=0.
- Multiply: md_start=1, md_is_div=0 one cycle, id_uses_hilo=1 thereafter → md_busy high 4 cycles, bubble asserted those 4 cycles, released on 5th; divide → 32 cycles.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles with load_use also true → all four stalls + clear_wb for 3 cycles, clear_ex=0; stall_cycles +3; then load_use bubble next cycle.
- Saturation/reset: force stall_cycles near 0xFFFF_FFFF (long stall) → holds at max; assert reset_n=0 mid-divide → md_busy=0, stall_cycles=0, clear_id/ex/wb=1 immediately, without clock edge.
